// File: rtl/fix_msg_builder.sv
// FIX 4.2 session message serializer: streams logon/logout/heartbeat/business frames as ASCII.
// Optional build macro FIX_SEQ_RESET_EN adds seq_reset_i to reload MsgSeqNum while idle.
module fix_msg_builder #(
    parameter int unsigned HB_INT   = 30,
    parameter int unsigned SEQ_INIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        initiate_msg_i,
    input  logic [2:0]  create_message_i,
`ifdef FIX_SEQ_RESET_EN
    input  logic        seq_reset_i,
`endif
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        tx_last_o,
    output logic        message_created_o,
    output logic        busy_o,
    output logic        bad_type_o,
    output logic [31:0] seq_num_o
);

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] bcd_inc(input logic [31:0] v);
        logic [31:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (carry) begin
                if (r[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = r[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic code_ok(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b100) || (c == 3'b010) || (c == 3'b111);
    endfunction

    localparam logic [31:0] SEQ_INIT_BCD = to_bcd(SEQ_INIT);
    localparam logic [7:0]  HB_D2 = 8'(32'h30 + (HB_INT / 100) % 10);
    localparam logic [7:0]  HB_D1 = 8'(32'h30 + (HB_INT / 10) % 10);
    localparam logic [7:0]  HB_D0 = 8'(32'h30 + HB_INT % 10);

    // Fixed text of the 41 pre-checksum bytes; variable fields are overlaid below.
    localparam logic [8*41-1:0] TMPL = {"8=FIX.4.2", 8'h01, "9=000", 8'h01, "35=0", 8'h01,
                                        "34=00000000", 8'h01, "108=000", 8'h01};

    typedef enum logic [2:0] {StIdle, StLoad, StHdr, StBody, StConv, StTrl, StDone} state_t;

    state_t      state;
    logic [2:0]  msg_type;
    logic [5:0]  idx;
    logic [7:0]  csum;
    logic [7:0]  rem;
    logic [1:0]  hund;
    logic [3:0]  tens;

    logic        logon;
    logic [5:0]  last_idx;
    logic [5:0]  sel_idx;
    logic [5:0]  rev_idx;
    logic [7:0]  type_char;
    logic [7:0]  gen_byte;
    logic [7:0]  trl_byte;

    assign logon    = (msg_type == 3'b001);
    assign last_idx = logon ? 6'd40 : 6'd32;

    always_comb begin
        type_char = "0";
        case (msg_type)
            3'b001:  type_char = "A";
            3'b100:  type_char = "5";
            3'b111:  type_char = "D";
            default: type_char = "0";
        endcase
    end

    // Byte for the index about to be presented (0 while loading, idx+1 after a handshake).
    always_comb begin
        sel_idx = (state == StLoad) ? 6'd0 : idx + 6'd1;
        if (sel_idx > 6'd40) sel_idx = 6'd40;
        rev_idx  = 6'd40 - sel_idx;
        gen_byte = TMPL[{rev_idx, 3'b000} +: 8];
        case (sel_idx)
            6'd13:   gen_byte = logon ? "2" : "1";
            6'd14:   gen_byte = logon ? "5" : "7";
            6'd19:   gen_byte = type_char;
            6'd37:   gen_byte = HB_D2;
            6'd38:   gen_byte = HB_D1;
            6'd39:   gen_byte = HB_D0;
            default: ;
        endcase
        for (int k = 0; k < 8; k++) begin
            if (sel_idx == 6'(24 + k)) gen_byte = {4'h3, seq_num_o[4*(7-k) +: 4]};
        end
    end

    always_comb begin
        case (idx)
            6'd0:    trl_byte = "0";
            6'd1:    trl_byte = "=";
            6'd2:    trl_byte = {4'h3, 2'b00, hund};
            6'd3:    trl_byte = {4'h3, tens};
            6'd4:    trl_byte = {4'h3, rem[3:0]};
            default: trl_byte = 8'h01;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= StIdle;
            msg_type          <= 3'b000;
            idx               <= 6'd0;
            csum              <= 8'd0;
            rem               <= 8'd0;
            hund              <= 2'd0;
            tens              <= 4'd0;
            tx_data_o         <= 8'd0;
            tx_valid_o        <= 1'b0;
            tx_last_o         <= 1'b0;
            message_created_o <= 1'b0;
            busy_o            <= 1'b0;
            bad_type_o        <= 1'b0;
            seq_num_o         <= SEQ_INIT_BCD;
        end else begin
            message_created_o <= 1'b0;
            bad_type_o        <= 1'b0;
            unique case (state)
                StIdle: begin
`ifdef FIX_SEQ_RESET_EN
                    if (seq_reset_i) seq_num_o <= SEQ_INIT_BCD;
`endif
                    if (initiate_msg_i) begin
                        if (code_ok(create_message_i)) begin
                            msg_type <= create_message_i;
                            busy_o   <= 1'b1;
                            state    <= StLoad;
                        end else begin
                            bad_type_o <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    csum       <= 8'd0;
                    idx        <= 6'd0;
                    tx_data_o  <= gen_byte;
                    tx_valid_o <= 1'b1;
                    state      <= StHdr;
                end
                StHdr, StBody: begin
                    if (tx_ready_i) begin
                        csum <= csum + tx_data_o;
                        if (idx == last_idx) begin
                            tx_valid_o <= 1'b0;
                            rem        <= csum + tx_data_o;
                            hund       <= 2'd0;
                            tens       <= 4'd0;
                            state      <= StConv;
                        end else begin
                            idx       <= idx + 6'd1;
                            tx_data_o <= gen_byte;
                            if (idx == 6'd20) state <= StBody;
                        end
                    end
                end
                StConv: begin
                    if (rem >= 8'd100) begin
                        rem  <= rem - 8'd100;
                        hund <= hund + 2'd1;
                    end else if (rem >= 8'd10) begin
                        rem  <= rem - 8'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        idx        <= 6'd0;
                        tx_data_o  <= "1";
                        tx_valid_o <= 1'b1;
                        state      <= StTrl;
                    end
                end
                StTrl: begin
                    if (tx_ready_i) begin
                        if (idx == 6'd6) begin
                            tx_valid_o        <= 1'b0;
                            tx_last_o         <= 1'b0;
                            message_created_o <= 1'b1;
                            busy_o            <= 1'b0;
                            seq_num_o         <= bcd_inc(seq_num_o);
                            state             <= StDone;
                        end else begin
                            idx       <= idx + 6'd1;
                            tx_data_o <= trl_byte;
                            if (idx == 6'd5) tx_last_o <= 1'b1;
                        end
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fix_msg_builder.sv
// Self-checking bench for fix_msg_builder: string-based FIX frame model, random backpressure.
// Honours FIX_SEQ_RESET_EN when the design is built with it.
module tb_fix_msg_builder;

    localparam int unsigned HB_TB       = 30;
    localparam int unsigned SEQ_INIT_TB = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        initiate = 1'b0;
    logic [2:0]  create_message = 3'b000;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        msg_created;
    logic        busy;
    logic        bad_type;
    logic [31:0] seq_num;
`ifdef FIX_SEQ_RESET_EN
    logic        seq_reset = 1'b0;
    logic        seq_reset_w = 1'b0;
`endif

    logic        initiate_w = 1'b0;
    logic [2:0]  create_w = 3'b010;
    logic        ready_w = 1'b1;
    logic [7:0]  data_w;
    logic        valid_w;
    logic        last_w;
    logic        created_w;
    logic        busy_w;
    logic        bad_w;
    logic [31:0] seq_w;

    always #5 clk = ~clk;

    fix_msg_builder #(.HB_INT(HB_TB), .SEQ_INIT(SEQ_INIT_TB)) dut (
        .clk               (clk),
        .rst               (rst),
        .initiate_msg_i    (initiate),
        .create_message_i  (create_message),
`ifdef FIX_SEQ_RESET_EN
        .seq_reset_i       (seq_reset),
`endif
        .tx_data_o         (tx_data),
        .tx_valid_o        (tx_valid),
        .tx_ready_i        (tx_ready),
        .tx_last_o         (tx_last),
        .message_created_o (msg_created),
        .busy_o            (busy),
        .bad_type_o        (bad_type),
        .seq_num_o         (seq_num)
    );

    fix_msg_builder #(.HB_INT(HB_TB), .SEQ_INIT(99999999)) dut_w (
        .clk               (clk),
        .rst               (rst),
        .initiate_msg_i    (initiate_w),
        .create_message_i  (create_w),
`ifdef FIX_SEQ_RESET_EN
        .seq_reset_i       (seq_reset_w),
`endif
        .tx_data_o         (data_w),
        .tx_valid_o        (valid_w),
        .tx_ready_i        (ready_w),
        .tx_last_o         (last_w),
        .message_created_o (created_w),
        .busy_o            (busy_w),
        .bad_type_o        (bad_w),
        .seq_num_o         (seq_w)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int unsigned model_seq = SEQ_INIT_TB;
    string       exp_s;
    logic [7:0]  got_q[$];
    bit          last_q[$];

    string lit1 = "8=FIX.4.2|9=017|35=0|34=00000001|10=042|";
    string lit2 = "8=FIX.4.2|9=025|35=A|34=00000001|108=030|10=164|";
    string lit3 = "8=FIX.4.2|9=017|35=5|34=00000002|10=048|";

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bcd(input int unsigned v);
        logic [31:0] r;
        void'($sscanf($sformatf("%08d", v), "%h", r));
        return r;
    endfunction

    // Frame built from the FIX rules: body length and checksum counted over the text itself.
    task automatic build_expected(input logic [2:0] code, input int unsigned seq);
        string soh, t, body, head;
        int unsigned sum;
        soh = $sformatf("%c", 8'h01);
        case (code)
            3'b001:  t = "A";
            3'b100:  t = "5";
            3'b010:  t = "0";
            default: t = "D";
        endcase
        body = {"35=", t, soh, $sformatf("34=%08d", seq), soh};
        if (code == 3'b001) body = {body, $sformatf("108=%03d", HB_TB), soh};
        head  = {"8=FIX.4.2", soh, $sformatf("9=%03d", body.len()), soh};
        exp_s = {head, body};
        sum   = 0;
        for (int i = 0; i < exp_s.len(); i++) sum += exp_s[i];
        exp_s = {exp_s, $sformatf("10=%03d", sum % 256), soh};
    endtask

    task automatic cmp_lit(input string tag, input string lit);
        logic [7:0] b;
        check({tag, "_len"}, got_q.size(), lit.len());
        for (int i = 0; i < lit.len() && i < got_q.size(); i++) begin
            b = (lit[i] == "|") ? 8'h01 : lit[i];
            check($sformatf("%s[%0d]", tag, i), got_q[i], b);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        model_seq = SEQ_INIT_TB;
    endtask

    task automatic run_msg(input logic [2:0] code, input bit rand_ready, input bit poke,
                           input bit sreset);
        bit         acc_last, done, stall, early;
        logic [7:0] held;
        int         cyc;
        if (sreset) model_seq = SEQ_INIT_TB;
        build_expected(code, model_seq);
        got_q.delete();
        last_q.delete();
        create_message = code;
        initiate = 1'b1;
`ifdef FIX_SEQ_RESET_EN
        seq_reset = sreset;
`endif
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
        initiate = 1'b0;
`ifdef FIX_SEQ_RESET_EN
        seq_reset = 1'b0;
`endif
        check("busy_on_accept", busy, 1);
        check("load_no_valid", tx_valid, 0);
        step();
        check("first_valid", tx_valid, 1);
        acc_last = 0; done = 0; stall = 0; early = 0; cyc = 0; held = '0;
        while (!done && cyc < 600) begin
            if (stall) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, held);
            end
            if (acc_last) begin
                check("created_after_last", msg_created, 1);
                done = 1;
            end else begin
                if (msg_created) early = 1;
                tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                initiate = poke && (got_q.size() == 10);
                if (initiate) create_message = 3'b010;
                if (tx_valid && tx_ready) begin
                    got_q.push_back(tx_data);
                    last_q.push_back(tx_last);
                    if (tx_last) acc_last = 1;
                end
                stall = tx_valid && !tx_ready;
                held  = tx_data;
                step();
                cyc++;
            end
        end
        initiate = 1'b0;
        tx_ready = 1'b1;
        check("msg_done", done, 1);
        check("early_created", early, 0);
        check("msg_len", got_q.size(), exp_s.len());
        for (int i = 0; i < exp_s.len() && i < got_q.size(); i++) begin
            check($sformatf("byte[%0d]", i), got_q[i], exp_s[i]);
            check($sformatf("last[%0d]", i), last_q[i], (i == exp_s.len() - 1));
        end
        model_seq = (model_seq + 1) % 100000000;
        step();
        check("created_one_cycle", msg_created, 0);
        check("busy_clear", busy, 0);
        step();
        step();
        check("no_queued_msg", tx_valid, 0);
        check("seq_after_msg", seq_num, bcd(model_seq));
    endtask

    initial begin
        int  cnt, cyc, n, lastn;
        bit  flag_v, flag_c, seen;

        // Reset state
        step();
        rst = 1'b0;
        step();
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_last", tx_last, 0);
        check("rst_created", msg_created, 0);
        check("rst_busy", busy, 0);
        check("rst_bad", bad_type, 0);
        check("rst_seq", seq_num, bcd(SEQ_INIT_TB));

        // Heartbeat, then logon after reset, then logout
        run_msg(3'b010, 0, 0, 0);
        cmp_lit("hb_lit", lit1);
        do_reset();
        run_msg(3'b001, 0, 0, 0);
        cmp_lit("logon_lit", lit2);
        run_msg(3'b100, 0, 0, 0);
        cmp_lit("logout_lit", lit3);

        // Backpressure plus an ignored request while busy
        do_reset();
        run_msg(3'b010, 1, 1, 0);
        cmp_lit("bp_lit", lit1);
        run_msg(3'b111, 1, 0, 0);

        // Unsupported code
        create_message = 3'b011;
        initiate = 1'b1;
        step();
        initiate = 1'b0;
        check("bad_pulse", bad_type, 1);
        check("bad_not_busy", busy, 0);
        step();
        check("bad_one_cycle", bad_type, 0);
        flag_v = 0;
        for (int i = 0; i < 4; i++) begin
            if (tx_valid) flag_v = 1;
            step();
        end
        check("bad_no_valid", flag_v, 0);
        check("bad_seq_same", seq_num, bcd(model_seq));

        // Reset in the middle of a logon
        create_message = 3'b001;
        initiate = 1'b1;
        tx_ready = 1'b1;
        step();
        initiate = 1'b0;
        cnt = 0;
        cyc = 0;
        while (cnt < 20 && cyc < 200) begin
            if (tx_valid && tx_ready) cnt++;
            step();
            cyc++;
        end
        check("abort_reached", cnt, 20);
        rst = 1'b1;
        #1;
        check("abort_valid", tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_data", tx_data, 0);
        check("abort_seq", seq_num, bcd(SEQ_INIT_TB));
        step();
        rst = 1'b0;
        model_seq = SEQ_INIT_TB;
        flag_v = 0;
        flag_c = 0;
        for (int i = 0; i < 6; i++) begin
            if (tx_valid) flag_v = 1;
            if (msg_created) flag_c = 1;
            step();
        end
        check("abort_no_bytes", flag_v, 0);
        check("abort_no_created", flag_c, 0);
        run_msg(3'b010, 0, 0, 0);
        cmp_lit("post_abort_lit", lit1);

`ifdef FIX_SEQ_RESET_EN
        run_msg(3'b010, 1, 0, 0);
        run_msg(3'b100, 0, 0, 0);
        run_msg(3'b010, 0, 0, 1);
        cmp_lit("seq_reset_lit", lit1);
`endif

        // Sequence number wrap on the second instance
        check("wrap_start_seq", seq_w, 32'h99999999);
        initiate_w = 1'b1;
        step();
        initiate_w = 1'b0;
        check("wrap_busy", busy_w, 1);
        n = 0;
        lastn = 0;
        seen = 0;
        cyc = 0;
        while (!seen && cyc < 200) begin
            if (created_w) seen = 1;
            else begin
                if (valid_w && ready_w) begin
                    if (n == 0) check("wrap_first_byte", data_w, "8");
                    n++;
                    if (last_w) lastn = n;
                end
                step();
                cyc++;
            end
        end
        check("wrap_done", seen, 1);
        check("wrap_len", n, 40);
        check("wrap_last_pos", lastn, 40);
        step();
        check("wrap_seq", seq_w, 32'h00000000);
        check("wrap_no_bad", bad_w, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
